// File: rtl/fx2_pkg.sv
// Shared definitions for the FX2 slave-FIFO scheduler: state encodings,
// endpoint addresses, strobe levels and the round-robin pick.
package fx2_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_SEL   = 3'd1,
    RD_BURST = 3'd2,
    WR_SEL   = 3'd3,
    WR_BURST = 3'd4,
    WR_PKT   = 3'd5,
    TURN     = 3'd6
  } state_e;

  typedef enum logic {
    SIDE_RD = 1'b0,
    SIDE_WR = 1'b1
  } side_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } grant_e;

  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP6_ADDR = 2'b10;

  // FX2 strobes (SLRD, SLOE, SLWR, PKTEND) are all active-low.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  // Round-robin pick: a lone requester wins; on a tie the side that did
  // not own the bus last time wins.
  function automatic grant_e rr_pick(input logic rd_req,
                                     input logic wr_req,
                                     input side_e rr_last);
    grant_e g;
    g = GNT_NONE;
    if (rd_req && wr_req) begin
      g = (rr_last == SIDE_RD) ? GNT_WR : GNT_RD;
    end else if (rd_req) begin
      g = GNT_RD;
    end else if (wr_req) begin
      g = GNT_WR;
    end
    return g;
  endfunction

endpackage

// File: rtl/fx2_fifo_scheduler.sv
// Arbitrates the shared FX2 FDATA bus between the EP2 read stream and the
// EP6 write stream with bounded bursts and a turnaround cycle between them.
module fx2_fifo_scheduler
  import fx2_pkg::*;
#(
  parameter int BURST_MAX = 16,
  parameter int CNT_W     = 9
) (
  input  logic        CLKOUT,
  input  logic        rst_n,
  input  logic        FLAGA,
  input  logic        FLAGD,
  output logic        SLRD,
  output logic        SLOE,
  output logic        SLWR,
  output logic        PKTEND,
  output logic [1:0]  FIFOADR,
  input  logic [15:0] fdata_in,
  output logic [15:0] fdata_out,
  output logic        fdata_oe,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic [2:0]  cState,
  output logic [15:0] RCount,
  output logic [15:0] WCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  state_e            state_q, state_d;
  side_e             rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        pkt_phase_q, pkt_phase_d;
  logic              slrd_q, slrd_d;
  logic              sloe_q, sloe_d;
  logic              slwr_q, slwr_d;
  logic              pktend_q, pktend_d;
  logic [1:0]        fifoadr_q, fifoadr_d;
  logic              oe_q, oe_d;
  logic [15:0]       fdata_out_q, fdata_out_d;
  logic [15:0]       rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [15:0]       rcount_q, rcount_d;
  logic [15:0]       wcount_q, wcount_d;

  logic   cnt_below;
  logic   rd_fire;
  logic   wr_ready;
  logic   wr_accept;
  grant_e grant;

  assign cnt_below = (cnt_q < CNT_MAX);
  assign rd_fire   = (state_q == RD_BURST) && FLAGA && rx_ready && cnt_below;
  assign wr_ready  = (state_q == WR_BURST) && FLAGD && cnt_below;
  assign wr_accept = wr_ready && tx_valid;
  assign grant     = rr_pick(FLAGA && rx_ready, FLAGD && tx_valid, rr_last_q);

  // Next-state and next-value logic for every registered pad and counter.
  // SLRD/SLWR pulse low in the cycle after the word was taken, so each
  // strobe acknowledges exactly one word to the FX2.
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    cnt_d       = cnt_q;
    pkt_phase_d = pkt_phase_q;
    slrd_d      = STROBE_OFF;
    sloe_d      = sloe_q;
    slwr_d      = STROBE_OFF;
    pktend_d    = STROBE_OFF;
    fifoadr_d   = fifoadr_q;
    oe_d        = oe_q;
    fdata_out_d = fdata_out_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rcount_d    = rcount_q;
    wcount_d    = wcount_q;

    case (state_q)
      IDLE: begin
        sloe_d = STROBE_OFF;
        oe_d   = 1'b0;
        case (grant)
          GNT_RD: begin
            state_d   = RD_SEL;
            fifoadr_d = EP2_ADDR;
            sloe_d    = STROBE_ON;
            cnt_d     = '0;
          end
          GNT_WR: begin
            state_d   = WR_SEL;
            fifoadr_d = EP6_ADDR;
            oe_d      = 1'b1;
            cnt_d     = '0;
          end
          default: ;
        endcase
      end

      RD_SEL: begin
        state_d = RD_BURST;
      end

      RD_BURST: begin
        if (rd_fire) begin
          slrd_d     = STROBE_ON;
          rx_data_d  = fdata_in;
          rx_valid_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          rcount_d   = rcount_q + 16'd1;
        end else begin
          state_d   = TURN;
          sloe_d    = STROBE_OFF;
          rr_last_d = SIDE_RD;
        end
      end

      WR_SEL: begin
        state_d = WR_BURST;
      end

      WR_BURST: begin
        if (wr_accept) begin
          fdata_out_d = tx_data;
          slwr_d      = STROBE_ON;
          cnt_d       = cnt_q + CNT_W'(1);
          wcount_d    = wcount_q + 16'd1;
          if (tx_last) begin
            state_d     = WR_PKT;
            pkt_phase_d = 2'd0;
            rr_last_d   = SIDE_WR;
          end
        end else begin
          state_d   = TURN;
          oe_d      = 1'b0;
          rr_last_d = SIDE_WR;
        end
      end

      WR_PKT: begin
        case (pkt_phase_q)
          2'd0: pkt_phase_d = 2'd1;
          2'd1: begin
            pkt_phase_d = 2'd2;
            pktend_d    = STROBE_ON;
          end
          default: begin
            pkt_phase_d = 2'd0;
            state_d     = TURN;
            oe_d        = 1'b0;
          end
        endcase
      end

      TURN: begin
        sloe_d  = STROBE_OFF;
        oe_d    = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        sloe_d  = STROBE_OFF;
        oe_d    = 1'b0;
      end
    endcase
  end

  // State and registered pad outputs; reset releases every strobe at once.
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_last_q   <= SIDE_WR;
      cnt_q       <= '0;
      pkt_phase_q <= 2'd0;
      slrd_q      <= STROBE_OFF;
      sloe_q      <= STROBE_OFF;
      slwr_q      <= STROBE_OFF;
      pktend_q    <= STROBE_OFF;
      fifoadr_q   <= EP2_ADDR;
      oe_q        <= 1'b0;
      fdata_out_q <= 16'h0000;
      rx_data_q   <= 16'h0000;
      rx_valid_q  <= 1'b0;
      rcount_q    <= 16'h0000;
      wcount_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      cnt_q       <= cnt_d;
      pkt_phase_q <= pkt_phase_d;
      slrd_q      <= slrd_d;
      sloe_q      <= sloe_d;
      slwr_q      <= slwr_d;
      pktend_q    <= pktend_d;
      fifoadr_q   <= fifoadr_d;
      oe_q        <= oe_d;
      fdata_out_q <= fdata_out_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rcount_q    <= rcount_d;
      wcount_q    <= wcount_d;
    end
  end

  assign SLRD      = slrd_q;
  assign SLOE      = sloe_q;
  assign SLWR      = slwr_q;
  assign PKTEND    = pktend_q;
  assign FIFOADR   = fifoadr_q;
  assign fdata_oe  = oe_q;
  assign fdata_out = fdata_out_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_ready  = wr_ready;
  assign cState    = state_q;
  assign RCount    = rcount_q;
  assign WCount    = wcount_q;

endmodule

// File: tb/tb_fx2_fifo_scheduler.sv
// Scoreboard bench for fx2_fifo_scheduler: an FX2 endpoint model feeds EP2
// words and drains EP6 words; a monitor checks every strobe against queues.
`timescale 1ns/1ps
module tb_fx2_fifo_scheduler;

  logic        CLKOUT = 1'b0;
  logic        rst_n;
  logic        FLAGA, FLAGD;
  logic        SLRD, SLOE, SLWR, PKTEND;
  logic [1:0]  FIFOADR;
  logic [15:0] fdata_in, fdata_out;
  logic        fdata_oe;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;
  logic [15:0] tx_data;
  logic        tx_valid, tx_last, tx_ready;
  logic [2:0]  cState;
  logic [15:0] RCount, WCount;

  int checks = 0;
  int errors = 0;

  logic [15:0] rd_q[$];
  logic [15:0] tx_dq[$];
  bit          tx_lq[$];
  logic [15:0] exp_rx[$];
  logic [15:0] exp_wr[$];
  int          exp_pkt = 0;
  int          slrd_cnt = 0;
  int          slwr_cnt = 0;
  int          pkt_cnt = 0;
  int          grant_log[$];

  fx2_fifo_scheduler #(.BURST_MAX(16), .CNT_W(9)) dut (
    .CLKOUT(CLKOUT), .rst_n(rst_n), .FLAGA(FLAGA), .FLAGD(FLAGD),
    .SLRD(SLRD), .SLOE(SLOE), .SLWR(SLWR), .PKTEND(PKTEND),
    .FIFOADR(FIFOADR), .fdata_in(fdata_in), .fdata_out(fdata_out),
    .fdata_oe(fdata_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready), .cState(cState),
    .RCount(RCount), .WCount(WCount)
  );

  always #5 CLKOUT = ~CLKOUT;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive the pads from the heads of the FX2 endpoint and tx source queues.
  task automatic refreshPads();
    FLAGA    = (rd_q.size() > 0);
    fdata_in = (rd_q.size() > 0) ? rd_q[0] : 16'h0000;
    tx_valid = (tx_dq.size() > 0);
    tx_data  = (tx_dq.size() > 0) ? tx_dq[0] : 16'h0000;
    tx_last  = (tx_lq.size() > 0) ? tx_lq[0] : 1'b0;
  endtask

  // One clock: EP2 consumes a word per SLRD-low cycle, tx source pops on accept.
  task automatic tick();
    logic acc;
    @(negedge CLKOUT);
    acc = tx_valid & tx_ready;
    @(posedge CLKOUT);
    #1;
    if (SLRD == 1'b0 && rd_q.size() > 0) void'(rd_q.pop_front());
    if (acc && tx_dq.size() > 0) begin
      void'(tx_dq.pop_front());
      void'(tx_lq.pop_front());
    end
    refreshPads();
  endtask

  task automatic applyStimulus(input int n_rd, input logic [15:0] rd_base,
                               input int n_wr, input logic [15:0] wr_base,
                               input bit with_last);
    for (int i = 0; i < n_rd; i++) begin
      rd_q.push_back(rd_base + 16'(i));
      exp_rx.push_back(rd_base + 16'(i));
    end
    for (int i = 0; i < n_wr; i++) begin
      tx_dq.push_back(wr_base + 16'(i));
      tx_lq.push_back(with_last && (i == n_wr - 1));
      exp_wr.push_back(wr_base + 16'(i));
    end
    if (with_last && n_wr > 0) exp_pkt++;
    refreshPads();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    grant_log.delete();
  endtask

  task automatic waitState(input logic [2:0] s, input string name);
    int n = 0;
    while (cState !== s && n < 300) begin tick(); n++; end
    checkOutput(name, 32'(cState), 32'(s));
  endtask

  task automatic waitRCount(input logic [15:0] v, input string name);
    int n = 0;
    while (RCount !== v && n < 300) begin tick(); n++; end
    checkOutput(name, 32'(RCount), 32'(v));
  endtask

  task automatic waitWCount(input logic [15:0] v, input string name);
    int n = 0;
    while (WCount !== v && n < 300) begin tick(); n++; end
    checkOutput(name, 32'(WCount), 32'(v));
  endtask

  // Monitor: pops the scoreboard on every rx_valid, SLWR and PKTEND cycle.
  initial begin : monitor
    logic [2:0] prev_state;
    logic       prev_slwr;
    prev_state = 3'd0;
    prev_slwr  = 1'b1;
    forever begin
      @(negedge CLKOUT);
      if (rst_n === 1'b1) begin
        checkOutput("sloe_oe_overlap", 32'(SLOE == 1'b0 && fdata_oe == 1'b1), 32'd0);
        if (rx_valid === 1'b1) begin
          checkOutput("rx_queue_nonempty", 32'(exp_rx.size() > 0), 32'd1);
          if (exp_rx.size() > 0)
            checkOutput("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
        end
        if (SLRD === 1'b0) begin
          slrd_cnt++;
          checkOutput("rd_pads", 32'({FIFOADR, SLOE}), 32'h0);
        end
        if (SLWR === 1'b0) begin
          slwr_cnt++;
          checkOutput("wr_pads", 32'({FIFOADR, fdata_oe}), 32'h5);
          checkOutput("wr_queue_nonempty", 32'(exp_wr.size() > 0), 32'd1);
          if (exp_wr.size() > 0)
            checkOutput("wr_data", 32'(fdata_out), 32'(exp_wr.pop_front()));
        end
        if (PKTEND === 1'b0) begin
          pkt_cnt++;
          checkOutput("pktend_expected", 32'(exp_pkt > 0), 32'd1);
          if (exp_pkt > 0) exp_pkt--;
          checkOutput("pktend_gap", 32'({prev_slwr, SLWR, cState, FIFOADR}), 32'h76);
        end
        if (prev_state == 3'd0 && (cState == 3'd1 || cState == 3'd3))
          grant_log.push_back(int'(cState));
      end
      prev_state = cState;
      prev_slwr  = SLWR;
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int s0, p0;
    rst_n    = 1'b0;
    FLAGD    = 1'b0;
    rx_ready = 1'b1;
    refreshPads();
    tick();
    tick();
    checkOutput("rst_strobes", 32'({SLRD, SLOE, SLWR, PKTEND}), 32'hF);
    checkOutput("rst_fifoadr_oe", 32'({FIFOADR, fdata_oe}), 32'h0);
    checkOutput("rst_rx", 32'({rx_valid, rx_data}), 32'h0);
    checkOutput("rst_fdata_out", 32'(fdata_out), 32'h0);
    checkOutput("rst_state", 32'(cState), 32'd0);
    checkOutput("rst_counts", {RCount, WCount}, 32'h0);
    rst_n = 1'b1;
    tick();

    $display("[TB] read of 5 words");
    applyStimulus(5, 16'h0001, 0, 16'h0000, 1'b0);
    waitRCount(16'd5, "read5_rcount");
    waitState(3'd0, "read5_idle");
    checkOutput("read5_slrd_pulses", 32'(slrd_cnt), 32'd5);
    checkOutput("read5_flaga_empty", 32'(FLAGA), 32'd0);

    $display("[TB] two full read bursts");
    doReset();
    applyStimulus(32, 16'h0100, 0, 16'h0000, 1'b0);
    waitState(3'd6, "burst_turn");
    checkOutput("burst_cap_rcount", 32'(RCount), 32'd16);
    checkOutput("burst_flaga_still_set", 32'(FLAGA), 32'd1);
    waitRCount(16'd32, "burst2_rcount");
    waitState(3'd0, "burst2_idle");
    checkOutput("burst2_grants", 32'(grant_log.size()), 32'd2);

    $display("[TB] packet of 3 words");
    FLAGD = 1'b1;
    applyStimulus(0, 16'h0000, 3, 16'hA001, 1'b1);
    waitWCount(16'd3, "wr3_wcount");
    waitState(3'd0, "wr3_idle");
    checkOutput("wr3_slwr_pulses", 32'(slwr_cnt), 32'd3);
    checkOutput("wr3_pktend_pulses", 32'(pkt_cnt), 32'd1);

    $display("[TB] tx_last on burst limit word");
    applyStimulus(0, 16'h0000, 16, 16'hD000, 1'b1);
    waitWCount(16'd19, "wr16_wcount");
    waitState(3'd0, "wr16_idle");
    checkOutput("wr16_pktend_pulses", 32'(pkt_cnt), 32'd2);

    $display("[TB] round-robin with both sides requesting");
    doReset();
    p0 = pkt_cnt;
    applyStimulus(20, 16'h0200, 4, 16'hB000, 1'b1);
    waitRCount(16'd20, "rr_rcount");
    waitState(3'd0, "rr_idle");
    checkOutput("rr_wcount", 32'(WCount), 32'd4);
    checkOutput("rr_pktend", 32'(pkt_cnt - p0), 32'd1);
    checkOutput("rr_grant_count", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() >= 3) begin
      checkOutput("rr_grant0_read", 32'(grant_log[0]), 32'd1);
      checkOutput("rr_grant1_write", 32'(grant_log[1]), 32'd3);
      checkOutput("rr_grant2_read", 32'(grant_log[2]), 32'd1);
    end

    $display("[TB] FLAGD drops mid-write");
    applyStimulus(0, 16'h0000, 6, 16'hC000, 1'b0);
    waitWCount(16'd6, "full_wcount_before");
    FLAGD = 1'b0;
    #1;
    checkOutput("full_tx_ready_low", 32'(tx_ready), 32'd0);
    tick();
    tick();
    s0 = slwr_cnt;
    repeat (5) tick();
    checkOutput("full_no_slwr", 32'(slwr_cnt), 32'(s0));
    checkOutput("full_wcount_hold", 32'(WCount), 32'd6);
    checkOutput("full_state_idle", 32'(cState), 32'd0);
    FLAGD = 1'b1;
    waitWCount(16'd10, "full_resume_wcount");
    waitState(3'd0, "full_resume_idle");

    $display("[TB] reset during read burst");
    applyStimulus(20, 16'h0300, 0, 16'h0000, 1'b0);
    waitRCount(16'd23, "rst_mid_rcount");
    checkOutput("rst_mid_in_burst", 32'(cState), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_strobes", 32'({SLRD, SLOE, SLWR, PKTEND}), 32'hF);
    checkOutput("rst_mid_state", 32'(cState), 32'd0);
    checkOutput("rst_mid_counts", {RCount, WCount}, 32'h0);
    checkOutput("rst_mid_oe", 32'(fdata_oe), 32'd0);
    rd_q.delete();
    exp_rx.delete();
    refreshPads();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] recovery read after reset");
    applyStimulus(2, 16'h0400, 0, 16'h0000, 1'b0);
    waitRCount(16'd2, "recover_rcount");
    waitState(3'd0, "recover_idle");
    tick();

    checkOutput("end_rx_drained", 32'(exp_rx.size()), 32'd0);
    checkOutput("end_wr_drained", 32'(exp_wr.size()), 32'd0);
    checkOutput("end_pkt_drained", 32'(exp_pkt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
